// File: rtl/gpi_axi_master.sv
// Bridges single GPI requests onto single-beat AXI read/write transactions.
// One transaction outstanding at a time; the response is held until accepted.
module gpi_axi_master #(
    parameter logic [5:0] AXI_ID   = 6'h0,
    parameter logic [2:0] AXI_PROT = 3'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [2:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [5:0]  axi_arid,
    output logic [31:0] axi_araddr,
    output logic [7:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    output logic [1:0]  axi_arlock,
    output logic [3:0]  axi_arcache,
    output logic [2:0]  axi_arprot,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [5:0]  axi_rid,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rlast,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [5:0]  axi_awid,
    output logic [31:0] axi_awaddr,
    output logic [7:0]  axi_awlen,
    output logic [2:0]  axi_awsize,
    output logic [1:0]  axi_awburst,
    output logic [1:0]  axi_awlock,
    output logic [3:0]  axi_awcache,
    output logic [2:0]  axi_awprot,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [5:0]  axi_wid,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wlast,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [5:0]  axi_bid,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  size_q, size_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;
    logic        aw_hs, w_hs;

    // Response IDs and rlast are deliberately ignored: only one beat is ever in flight.
    logic unused_inputs;
    assign unused_inputs = ^{axi_rid, axi_rlast, axi_bid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            size_q    <= size_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        size_d      = size_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    size_d  = req_size;
                    state_d = req_write ? WRITE : RADDR;
                end
            end
            RADDR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) state_d = RDATA;
            end
            RDATA: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    rdata_d = axi_rdata;
                    error_d = (axi_rresp != 2'b00);
                    state_d = RESP;
                end
            end
            WRITE: begin
                // Address and data channels complete independently, possibly in the same cycle.
                axi_awvalid = !aw_done_q;
                axi_wvalid  = !w_done_q;
                aw_hs       = axi_awvalid && axi_awready;
                w_hs        = axi_wvalid && axi_wready;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WRESP;
                end else begin
                    aw_done_d = aw_done_q || aw_hs;
                    w_done_d  = w_done_q || w_hs;
                end
            end
            WRESP: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    rdata_d = '0;
                    error_d = (axi_bresp != 2'b00);
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_rdata  = rdata_q;
    assign resp_error  = error_q;

    assign axi_arid    = AXI_ID;
    assign axi_araddr  = addr_q;
    assign axi_arlen   = 8'h00;
    assign axi_arsize  = size_q;
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 2'b00;
    assign axi_arcache = 4'h0;
    assign axi_arprot  = AXI_PROT;

    assign axi_awid    = AXI_ID;
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = 8'h00;
    assign axi_awsize  = size_q;
    assign axi_awburst = 2'b01;
    assign axi_awlock  = 2'b00;
    assign axi_awcache = 4'h0;
    assign axi_awprot  = AXI_PROT;

    assign axi_wid     = AXI_ID;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wlast   = 1'b1;

endmodule
